pwm_duty_sweeper: RTL and testbench
===================================

Name: pwm_duty_sweeper

Overview:
- Upstream duty-cycle source for the 8-bit PWM stage: drives the PWM `threshold` input with a programmed sweep of duty values.
- Runs a free-running frame counter aligned to the PWM's 2^FRAME_LOG2-cycle period and updates `threshold` only on frame boundaries, so no glitched PWM periods occur.
- Configured through a valid/ready handshake; supports one-shot sawtooth, repeating sawtooth and triangle sweeps.

Parameters:
- FRAME_LOG2, 8, log2 of frame length in clocks; must equal the PWM counter width (8).
- HOLD_W, 8, width of the frames-per-step hold counter and of cfg_hold.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- cfg_valid  input  1  configuration/start request.
- cfg_ready  output  1  configuration accepted when high with cfg_valid.
- cfg_min  input  8  sweep start/lower duty.
- cfg_max  input  8  sweep upper duty.
- cfg_step  input  8  duty increment per update; 0 treated as 1.
- cfg_hold  input  HOLD_W  frames each duty value is held; 0 treated as 1.
- cfg_mode  input  2  0 saw-once, 1 saw-repeat, 2 triangle, 3 treated as 0.
- stop  input  1  synchronous abort.
- threshold  output  8  duty value to PWM.
- frame_start  output  1  one-cycle pulse when frame counter = 0 while busy.
- busy  output  1  high in RUN_UP/RUN_DOWN.
- done  output  1  one-cycle pulse on entry to DONE.

Behaviour:
- Reset (async, rst_n low) sets:
  - state IDLE, threshold 0, frame counter 0, hold counter 0, busy 0, done 0, frame_start 0.
  - Latched config: min=max=0, step=1, hold=1, mode 0.
- States: IDLE, RUN_UP, RUN_DOWN, DONE.
- cfg_ready = (state IDLE or DONE) and not stop. Stop wins over a simultaneous cfg_valid.
- Accept (cfg_valid & cfg_ready) on edge E:
  - Latch config, with effective max = max(cfg_min, cfg_max).
  - threshold <= cfg_min; frame counter <= 0; hold counter <= 0; state <= RUN_UP.
  - busy high from E+1; frame_start high in cycle E+1.
- Frame counter:
  - Increments every clock while busy; wraps from 2^FRAME_LOG2-1 to 0.
  - Held at 0 in IDLE/DONE.
- Update point: the edge where frame counter = 2^FRAME_LOG2-1 and hold counter = hold-1.
  - Hold counter resets to 0 at the update point; otherwise it increments at each frame end.
  - The new threshold appears at counter = 0, i.e. on the first cycle of the next frame.
- Arithmetic: 9-bit intermediate; up = min(duty+step, max); down = max(duty-step, min), with no underflow below 0.
- RUN_UP at update point:
  - duty < max: duty <= up.
  - duty == max, mode 0: state DONE, done pulse, threshold stays at max.
  - duty == max, mode 1: duty <= min.
  - duty == max, mode 2: state RUN_DOWN, duty <= down.
- RUN_DOWN at update point:
  - duty > min: duty <= down.
  - duty == min: state RUN_UP, duty <= up.
- Degenerate min ≥ max:
  - Duty stays at min.
  - Mode 0 reaches DONE at the first update point.
  - Modes 1 and 2 run indefinitely at min.
- stop while busy:
  - Next edge: state IDLE, busy 0, frame counter 0.
  - threshold holds its current value; no done pulse.
- DONE behaves as IDLE except done was pulsed; a new accept restarts the sweep.
- Reset mid-sweep returns immediately to reset values regardless of state.

Optional Feature:
- Macro: PWM_DUTY_SWEEPER_GAMMA_EN.
- Defined:
  - threshold = (duty*duty)>>8 using a 16-bit product, registered.
  - Output latency is unchanged: the squared value appears on the same frame boundary.
  - Example: duty 128 -> threshold 64; duty 255 -> threshold 254.
- Undefined: threshold = duty directly. The internal duty register is identical in both builds.

Test Plan:
- Reset/defaults: hold rst_n low mid-run -> threshold 0, busy 0, cfg_ready 1, frame_start 0 immediately.
- Saw-once sweep:
  - Stimulus: min=10, max=40, step=10, hold=1, mode 0.
  - Response: threshold 10,20,30,40, each change at cycle 256·k after accept+1.
  - Then done pulses once; busy drops; threshold stays 40.
- Triangle with saturation:
  - Stimulus: min=0, max=25, step=10, mode 2.
  - Response: sequence 0,10,20,25,15,5,0,10; no underflow or overflow.
- Hold and zero-step:
  - Stimulus: step=0, hold=3, mode 1, min=254, max=255.
  - Response: each value lasts 768 cycles; sequence 254,255,254.
- Stop vs config:
  - Stimulus: stop and cfg_valid asserted together while busy.
  - Response: IDLE next cycle, no accept, threshold frozen.
  - Following cycle: cfg_valid alone is accepted.
- Gamma build with macro:
  - Stimulus: min=max=128, mode 1.
  - Response: threshold 64; without macro, threshold 128.

Source files
------------

// File: rtl/pwm_duty_sweeper.sv
// Duty-cycle sweep generator for the 8-bit PWM stage; threshold changes only on frame boundaries.
// Optional build macro PWM_DUTY_SWEEPER_GAMMA_EN squares the duty value ((duty*duty)>>8) before output.
module pwm_duty_sweeper #(
  parameter int FRAME_LOG2 = 8,
  parameter int HOLD_W     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [7:0]        cfg_min,
  input  logic [7:0]        cfg_max,
  input  logic [7:0]        cfg_step,
  input  logic [HOLD_W-1:0] cfg_hold,
  input  logic [1:0]        cfg_mode,
  input  logic              stop,
  output logic [7:0]        threshold,
  output logic              frame_start,
  output logic              busy,
  output logic              done
);

  // state    | meaning
  // IDLE     | waiting for configuration, frame counter parked at 0
  // RUN_UP   | duty rising toward max on each update point
  // RUN_DOWN | duty falling toward min (triangle mode only)
  // DONE     | one-shot sweep finished, otherwise identical to IDLE
  typedef enum logic [1:0] {IDLE, RUN_UP, RUN_DOWN, DONE} state_t;

  state_t                state, state_nx;
  logic [FRAME_LOG2-1:0] frame_cnt, frame_cnt_nx;
  logic [HOLD_W-1:0]     hold_cnt, hold_cnt_nx;
  logic [7:0]            duty, duty_nx;
  logic                  done_q, done_nx;

  logic [7:0]            min_q, max_q, step_q;
  logic [HOLD_W-1:0]     hold_q;
  logic [1:0]            mode_q;

  logic                  accept, frame_end, hold_last;
  logic [8:0]            up_sum, dn_diff;
  logic [7:0]            up_val, dn_clamp, dn_val;

  assign busy        = (state == RUN_UP) || (state == RUN_DOWN);
  assign cfg_ready   = ((state == IDLE) || (state == DONE)) && !stop;
  assign accept      = cfg_valid && cfg_ready;
  assign frame_start = busy && (frame_cnt == '0);
  assign frame_end   = (frame_cnt == '1);
  assign hold_last   = (hold_cnt == hold_q - HOLD_W'(1));
  assign done        = done_q;

  // 9-bit arithmetic so saturation at max and clamping at 0 are exact
  assign up_sum   = {1'b0, duty} + {1'b0, step_q};
  assign up_val   = (up_sum > {1'b0, max_q}) ? max_q : up_sum[7:0];
  assign dn_diff  = {1'b0, duty} - {1'b0, step_q};
  assign dn_clamp = dn_diff[8] ? 8'd0 : dn_diff[7:0];
  assign dn_val   = (dn_clamp < min_q) ? min_q : dn_clamp;

  always_comb begin
    state_nx     = state;
    duty_nx      = duty;
    frame_cnt_nx = frame_cnt;
    hold_cnt_nx  = hold_cnt;
    done_nx      = 1'b0;
    case (state)
      IDLE, DONE: begin
        frame_cnt_nx = '0;
        hold_cnt_nx  = '0;
        if (accept) begin
          duty_nx  = cfg_min;
          state_nx = RUN_UP;
        end
      end
      RUN_UP, RUN_DOWN: begin
        if (stop) begin
          state_nx     = IDLE;
          frame_cnt_nx = '0;
          hold_cnt_nx  = '0;
        end else begin
          frame_cnt_nx = frame_cnt + FRAME_LOG2'(1);
          if (frame_end) begin
            if (!hold_last) begin
              hold_cnt_nx = hold_cnt + HOLD_W'(1);
            end else begin
              hold_cnt_nx = '0;
              if (state == RUN_UP) begin
                if (duty < max_q) begin
                  duty_nx = up_val;
                end else begin
                  case (mode_q)
                    2'd1: duty_nx = min_q;
                    2'd2: begin
                      state_nx = RUN_DOWN;
                      duty_nx  = dn_val;
                    end
                    default: begin
                      state_nx = DONE;
                      done_nx  = 1'b1;
                    end
                  endcase
                end
              end else begin
                if (duty > min_q) begin
                  duty_nx = dn_val;
                end else begin
                  state_nx = RUN_UP;
                  duty_nx  = up_val;
                end
              end
            end
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      frame_cnt <= '0;
      hold_cnt  <= '0;
      duty      <= 8'd0;
      done_q    <= 1'b0;
    end else begin
      state     <= state_nx;
      frame_cnt <= frame_cnt_nx;
      hold_cnt  <= hold_cnt_nx;
      duty      <= duty_nx;
      done_q    <= done_nx;
    end
  end

  // Zero step/hold are promoted to 1 and mode 3 folds to one-shot at latch time
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      min_q  <= 8'd0;
      max_q  <= 8'd0;
      step_q <= 8'd1;
      hold_q <= HOLD_W'(1);
      mode_q <= 2'd0;
    end else if (accept) begin
      min_q  <= cfg_min;
      max_q  <= (cfg_max < cfg_min) ? cfg_min : cfg_max;
      step_q <= (cfg_step == 8'd0) ? 8'd1 : cfg_step;
      hold_q <= (cfg_hold == '0) ? HOLD_W'(1) : cfg_hold;
      mode_q <= (cfg_mode == 2'd3) ? 2'd0 : cfg_mode;
    end
  end

`ifdef PWM_DUTY_SWEEPER_GAMMA_EN
  logic [15:0] duty_sq;
  logic [7:0]  thr_q;

  // Square the next duty so the curved value lands on the same edge as the raw one
  assign duty_sq = {8'd0, duty_nx} * {8'd0, duty_nx};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      thr_q <= 8'd0;
    end else begin
      thr_q <= duty_sq[15:8];
    end
  end

  assign threshold = thr_q;
`else
  assign threshold = duty;
`endif

endmodule

// File: tb/tb_pwm_duty_sweeper.sv
// Directed self-checking bench for pwm_duty_sweeper: saw-once, triangle, hold/zero-step,
// stop-vs-config, gamma mapping and asynchronous reset.
module tb_pwm_duty_sweeper;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [7:0] cfg_min, cfg_max, cfg_step;
  logic [7:0] cfg_hold;
  logic [1:0] cfg_mode;
  logic       stop;
  logic [7:0] threshold;
  logic       frame_start, busy, done;

  int n_cmp = 0;
  int n_bad = 0;

  pwm_duty_sweeper #(.FRAME_LOG2(8), .HOLD_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_min    (cfg_min),
    .cfg_max    (cfg_max),
    .cfg_step   (cfg_step),
    .cfg_hold   (cfg_hold),
    .cfg_mode   (cfg_mode),
    .stop       (stop),
    .threshold  (threshold),
    .frame_start(frame_start),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  // Expected PWM threshold for a given internal duty value
  function automatic logic [7:0] thr_of(input int d);
`ifdef PWM_DUTY_SWEEPER_GAMMA_EN
    return 8'((d * d) >> 8);
`else
    return 8'(d);
`endif
  endfunction

  // Advance n clocks, sampling 1ns after the last rising edge
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start(input int mn, input int mx, input int st, input int hd, input int md);
    cfg_min   = 8'(mn);
    cfg_max   = 8'(mx);
    cfg_step  = 8'(st);
    cfg_hold  = 8'(hd);
    cfg_mode  = 2'(md);
    cfg_valid = 1'b1;
    cyc(1);
    cfg_valid = 1'b0;
  endtask

  initial begin
    int tri_seq[8];
    tri_seq = '{0, 10, 20, 25, 15, 5, 0, 10};

    rst_n = 1'b0; cfg_valid = 1'b0; stop = 1'b0;
    cfg_min = 8'd0; cfg_max = 8'd0; cfg_step = 8'd0; cfg_hold = 8'd0; cfg_mode = 2'd0;
    #22;
    check("rst_thr",   16'(threshold), 16'd0);
    check("rst_busy",  16'(busy),      16'd0);
    check("rst_ready", 16'(cfg_ready), 16'd1);
    rst_n = 1'b1;
    cyc(2);

    // Saw-once 10..40 by 10, hold 1
    start(10, 40, 10, 1, 0);
    check("saw_thr0", 16'(threshold),   16'(thr_of(10)));
    check("saw_busy", 16'(busy),        16'd1);
    check("saw_fs0",  16'(frame_start), 16'd1);
    cyc(1);
    check("saw_fs1",  16'(frame_start), 16'd0);
    cyc(254);
    check("saw_thr_edge", 16'(threshold), 16'(thr_of(10)));
    cyc(1);
    check("saw_thr1", 16'(threshold),   16'(thr_of(20)));
    check("saw_fs_k", 16'(frame_start), 16'd1);
    cyc(256);
    check("saw_thr2", 16'(threshold), 16'(thr_of(30)));
    cyc(256);
    check("saw_thr3", 16'(threshold), 16'(thr_of(40)));
    check("saw_nodone", 16'(done),    16'd0);
    cyc(256);
    check("saw_done",  16'(done),      16'd1);
    check("saw_idle",  16'(busy),      16'd0);
    check("saw_hold",  16'(threshold), 16'(thr_of(40)));
    check("saw_ready", 16'(cfg_ready), 16'd1);
    cyc(1);
    check("saw_done1", 16'(done),      16'd0);
    check("saw_keep",  16'(threshold), 16'(thr_of(40)));

    // Triangle 0..25 step 10, saturating at both ends
    start(0, 25, 10, 1, 2);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("tri_%0d", i), 16'(threshold), 16'(thr_of(tri_seq[i])));
      check($sformatf("tri_busy_%0d", i), 16'(busy), 16'd1);
      if (i < 7) cyc(256);
    end

    // Stop together with cfg_valid while busy: stop wins, threshold frozen
    cyc(3);
    cfg_min = 8'd254; cfg_max = 8'd255; cfg_step = 8'd0; cfg_hold = 8'd3; cfg_mode = 2'd1;
    stop = 1'b1; cfg_valid = 1'b1;
    check("stop_ready", 16'(cfg_ready), 16'd0);
    cyc(1);
    check("stop_busy", 16'(busy),      16'd0);
    check("stop_thr",  16'(threshold), 16'(thr_of(10)));
    check("stop_done", 16'(done),      16'd0);
    check("stop_fs",   16'(frame_start), 16'd0);
    stop = 1'b0;
    #1;
    check("stop_ready2", 16'(cfg_ready), 16'd1);
    cyc(1);
    cfg_valid = 1'b0;

    // Accepted config: step 0 -> 1, hold 3, repeat 254..255
    check("hold_busy", 16'(busy),      16'd1);
    check("hold_thr0", 16'(threshold), 16'(thr_of(254)));
    cyc(767);
    check("hold_edge", 16'(threshold), 16'(thr_of(254)));
    cyc(1);
    check("hold_thr1", 16'(threshold), 16'(thr_of(255)));
    cyc(767);
    check("hold_edge2", 16'(threshold), 16'(thr_of(255)));
    cyc(1);
    check("hold_thr2", 16'(threshold), 16'(thr_of(254)));

    // Degenerate min=max=128, repeat: stays at 128 (64 with gamma)
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;
    start(128, 128, 5, 1, 1);
    check("gam_thr0", 16'(threshold), 16'(thr_of(128)));
    cyc(256);
    check("gam_thr1", 16'(threshold), 16'(thr_of(128)));
    check("gam_busy", 16'(busy),      16'd1);

    // Asynchronous reset mid-run, checked before any clock edge
    cyc(40);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_thr",   16'(threshold),   16'd0);
    check("arst_busy",  16'(busy),        16'd0);
    check("arst_ready", 16'(cfg_ready),   16'd1);
    check("arst_fs",    16'(frame_start), 16'd0);
    check("arst_done",  16'(done),        16'd0);
    cyc(2);
    rst_n = 1'b1;
    cyc(2);

    // Mode 3 behaves as one-shot; degenerate range finishes at first update point
    start(50, 20, 1, 1, 3);
    check("m3_thr", 16'(threshold), 16'(thr_of(50)));
    cyc(256);
    check("m3_done", 16'(done),      16'd1);
    check("m3_thr1", 16'(threshold), 16'(thr_of(50)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
